reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter Width, default 32, data bits per register.
REQ-002 SHALL have parameter Depth, default 32, register count; AW = $clog2(Depth).
REQ-003 SHALL have parameter NumRd, default 2, core read ports (1..4).
REQ-004 SHALL have parameter NumWr, default 1, core write ports (1..2).
REQ-005 SHALL have parameter ZeroReg, default 1; 1 = register 0 hardwired to zero.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 rd_addr  in  NumRd x AW  core read addresses.
REQ-009 rd_data  out  NumRd x Width  core read data, combinational.
REQ-010 wr_en  in  NumWr  per-port core write enable.
REQ-011 wr_addr  in  NumWr x AW  core write addresses.
REQ-012 wr_data  in  NumWr x Width  core write data.
REQ-013 dbg_req  in  1  debug access request, held high until dbg_ack.
REQ-014 dbg_we  in  1  debug access type: 1 write, 0 read; stable while dbg_req high.
REQ-015 dbg_addr  in  AW  debug register address; stable while dbg_req high.
REQ-016 dbg_wdata  in  Width  debug write data; stable while dbg_req high.
REQ-017 dbg_ack  out  1  one-cycle completion pulse.
REQ-018 dbg_rdata  out  Width  registered debug read data, valid when dbg_ack=1.

Function
REQ-019 Core writes SHALL update the array on the rising edge when wr_en[i]=1.
REQ-020 Same-cycle core writes to one address SHALL resolve highest port index wins.
REQ-021 With ZeroReg=1: writes to address 0 (core or debug) SHALL be dropped; reads of address 0 SHALL return 0.
REQ-022 Addresses >= Depth SHALL read 0 and writes to them SHALL be dropped.
REQ-023 Debug FSM states SHALL be IDLE, STALL, DONE.
REQ-024 IDLE with dbg_req=1: if dbg_we=1 and any wr_en=1, SHALL go to STALL with no access; otherwise SHALL perform the access this edge and go to DONE.
REQ-025 STALL: SHALL repeat the REQ-024 check each cycle; core writes always have priority over debug writes.
REQ-026 Debug read SHALL capture the array value before that edge's updates into dbg_rdata.
REQ-027 Debug write SHALL update the array at the access edge; the value is visible on rd_data from the next cycle.
REQ-028 DONE SHALL assert dbg_ack for exactly one cycle, then return to IDLE.
REQ-029 In DONE, dbg_req SHALL be ignored; a request still high in the following IDLE cycle SHALL be treated as a new access.
REQ-030 dbg_rdata SHALL hold its value until the next debug read completes; a debug write SHALL not change it.
REQ-031 dbg_req falling in STALL SHALL abort the access and return to IDLE with no write and no ack.

Reset
REQ-032 rst=1 SHALL asynchronously clear all registers to 0, set the FSM to IDLE, dbg_ack=0 and dbg_rdata=0.
REQ-033 A reset during STALL or DONE SHALL discard the pending access; no ack SHALL follow.

Configuration
REQ-034 Macro REG_FILE_MP_BYPASS_EN defined: rd_data[j] SHALL forward wr_data of the highest-index enabled core write port matching rd_addr[j] (address 0 excluded when ZeroReg=1) in the same cycle.
REQ-035 Macro REG_FILE_MP_BYPASS_EN undefined: rd_data SHALL return the array contents, i.e. the pre-write value during a write cycle.

Verification
REQ-036 Reset, then read all addresses on every port -> all 0, dbg_ack=0, dbg_rdata=0.
REQ-037 NumWr=2: wr_en=2'b11, both to addr 5, data 0xAAAA_0001/0xBBBB_0002 -> addr 5 reads 0xBBBB_0002; write 0x1234 to addr 0 -> reads 0.
REQ-038 Write 0xDEAD_BEEF to addr 7 and read addr 7 in the same cycle -> 0xDEAD_BEEF with bypass, previous value without bypass; next cycle 0xDEAD_BEEF in both builds.
REQ-039 dbg_req write 0x55 to addr 3 while wr_en=1 for 3 cycles -> STALL 3 cycles, then write, ack one cycle later; addr 3 reads 0x55.
REQ-040 Debug read of addr 9 holding 0x0F0F -> dbg_ack high exactly one cycle after acceptance with dbg_rdata=0x0F0F; assert rst in DONE -> ack low immediately, dbg_rdata=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with a handshaked debug port that stalls behind core writes.
// Optional same-cycle write-to-read forwarding: define REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
  parameter int Width   = 32,
  parameter int Depth   = 32,
  parameter int NumRd   = 2,
  parameter int NumWr   = 1,
  parameter int ZeroReg = 1,
  localparam int AW     = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NumRd-1:0][AW-1:0]    rd_addr_i,
  output logic [NumRd-1:0][Width-1:0] rd_data_o,
  input  logic [NumWr-1:0]            wr_en_i,
  input  logic [NumWr-1:0][AW-1:0]    wr_addr_i,
  input  logic [NumWr-1:0][Width-1:0] wr_data_i,
  input  logic                        dbg_req_i,
  input  logic                        dbg_we_i,
  input  logic [AW-1:0]               dbg_addr_i,
  input  logic [Width-1:0]            dbg_wdata_i,
  output logic                        dbg_ack_o,
  output logic [Width-1:0]            dbg_rdata_o
);

  typedef enum logic [1:0] {IDLE, STALL, DONE} dbg_state_e;

  logic [Width-1:0] mem_q [Depth];
  dbg_state_e       state_q;
  logic             dbg_ack_q;
  logic [Width-1:0] dbg_rdata_q;
  logic             dbg_go;
  logic             dbg_wr_fire;

  // An address is live when it exists and is not the hardwired zero register.
  function automatic logic live(input logic [AW-1:0] a);
    logic in_range;
    in_range = {1'b0, a} < (AW+1)'(Depth);
    return in_range && !((ZeroReg != 0) && (a == '0));
  endfunction

  function automatic logic [Width-1:0] arr_read(input logic [AW-1:0] a);
    return live(a) ? mem_q[a] : '0;
  endfunction

  assign dbg_go      = dbg_req_i && (state_q != DONE) && !(dbg_we_i && (|wr_en_i));
  assign dbg_wr_fire = dbg_go && dbg_we_i;

  // Debug writes only fire when no core port is writing, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (dbg_wr_fire && live(dbg_addr_i)) mem_q[dbg_addr_i] <= dbg_wdata_i;
      for (int p = 0; p < NumWr; p++) begin
        if (wr_en_i[p] && live(wr_addr_i[p])) mem_q[wr_addr_i[p]] <= wr_data_i[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      dbg_ack_q <= 1'b0;
      unique case (state_q)
        IDLE, STALL: begin
          if (!dbg_req_i) begin
            state_q <= IDLE;
          end else if (dbg_go) begin
            state_q   <= DONE;
            dbg_ack_q <= 1'b1;
            if (!dbg_we_i) dbg_rdata_q <= arr_read(dbg_addr_i);
          end else begin
            state_q <= STALL;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < NumRd; j++) begin
      rd_data_o[j] = arr_read(rd_addr_i[j]);
`ifdef REG_FILE_MP_BYPASS_EN
      for (int p = 0; p < NumWr; p++) begin
        if (wr_en_i[p] && live(wr_addr_i[p]) && (wr_addr_i[p] == rd_addr_i[j]))
          rd_data_o[j] = wr_data_i[p];
      end
`endif
    end
  end

  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: table-driven core port vectors plus debug handshake sequences.
module tb_reg_file_mp;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0][A-1:0] rd_addr;
  logic [1:0][W-1:0] rd_data;
  logic [1:0]        wr_en;
  logic [1:0][A-1:0] wr_addr;
  logic [1:0][W-1:0] wr_data;
  logic              dbg_req, dbg_we;
  logic [A-1:0]      dbg_addr;
  logic [W-1:0]      dbg_wdata;
  logic              dbg_ack;
  logic [W-1:0]      dbg_rdata;

  reg_file_mp #(.Width(W), .Depth(D), .NumRd(2), .NumWr(2), .ZeroReg(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [W:0] exp;
  } exp_t;

  typedef struct {
    logic         we0;
    logic [A-1:0] wa0;
    logic [W-1:0] wd0;
    logic         we1;
    logic [A-1:0] wa1;
    logic [W-1:0] wd1;
    logic [A-1:0] ra0;
    logic [A-1:0] ra1;
    logic [W-1:0] e0;   // expected without forwarding
    logic [W-1:0] e1;
    logic [W-1:0] b0;   // expected with forwarding
    logic [W-1:0] b1;
  } vec_t;

  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic push(input string name, input logic [W:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [W:0] act);
    exp_t e;
    n_run++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got 0x%h, want an entry", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h, want 0x%h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic idle_in();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ack(input string name, input logic exp);
    push(name, {{W{1'b0}}, exp});
    pop_cmp({{W{1'b0}}, dbg_ack});
  endtask

  task automatic chk_rd(input string name, input logic [A-1:0] a, input logic [W-1:0] exp);
    rd_addr[0] = a;
    #1;
    push(name, {1'b0, exp});
    pop_cmp({1'b0, rd_data[0]});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd5,  5'd7,
               32'h0,         32'h0,         32'h0,         32'h0};
    tbl[1] = '{1'b1, 5'd5,  32'hAAAA_0001, 1'b1, 5'd5,  32'hBBBB_0002, 5'd5,  5'd0,
               32'h0,         32'h0,         32'hBBBB_0002, 32'h0};
    tbl[2] = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         5'd5,  5'd0,
               32'hBBBB_0002, 32'h0,         32'hBBBB_0002, 32'h0};
    tbl[3] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  5'd5,
               32'h0,         32'hBBBB_0002, 32'h0,         32'hBBBB_0002};
    tbl[4] = '{1'b1, 5'd9,  32'h0000_0F0F, 1'b1, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd9,
               32'h0,         32'h0,         32'hDEAD_BEEF, 32'h0000_0F0F};
    tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd7,  5'd9,
               32'hDEAD_BEEF, 32'h0000_0F0F, 32'hDEAD_BEEF, 32'h0000_0F0F};
    tbl[6] = '{1'b1, 5'd7,  32'h1111_1111, 1'b0, 5'd0,  32'h0,         5'd7,  5'd3,
               32'hDEAD_BEEF, 32'h0,         32'h1111_1111, 32'h0};
    tbl[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd7,  5'd5,
               32'h1111_1111, 32'hBBBB_0002, 32'h1111_1111, 32'hBBBB_0002};
    tbl[8] = '{1'b1, 5'd31, 32'h0000_CAFE, 1'b1, 5'd31, 32'h0000_F00D, 5'd31, 5'd1,
               32'h0,         32'h0,         32'h0000_F00D, 32'h0};
    tbl[9] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         5'd31, 5'd31,
               32'h0000_F00D, 32'h0000_F00D, 32'h0000_F00D, 32'h0000_F00D};

    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: every address reads zero on both ports.
    for (int a = 0; a < D; a++) begin
      rd_addr[0] = A'(a);
      rd_addr[1] = A'(D - 1 - a);
      #1;
      push($sformatf("reset_rd0_a%0d", a), '0);
      push($sformatf("reset_rd1_a%0d", D - 1 - a), '0);
      pop_cmp({1'b0, rd_data[0]});
      pop_cmp({1'b0, rd_data[1]});
    end
    chk_ack("reset_ack", 1'b0);
    push("reset_rdata", '0);
    pop_cmp({1'b0, dbg_rdata});

    // Core port vectors.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      wr_en      = {tbl[i].we1, tbl[i].we0};
      wr_addr[0] = tbl[i].wa0;
      wr_addr[1] = tbl[i].wa1;
      wr_data[0] = tbl[i].wd0;
      wr_data[1] = tbl[i].wd1;
      rd_addr[0] = tbl[i].ra0;
      rd_addr[1] = tbl[i].ra1;
`ifdef REG_FILE_MP_BYPASS_EN
      push($sformatf("vec%0d_rd0", i), {1'b0, tbl[i].b0});
      push($sformatf("vec%0d_rd1", i), {1'b0, tbl[i].b1});
`else
      push($sformatf("vec%0d_rd0", i), {1'b0, tbl[i].e0});
      push($sformatf("vec%0d_rd1", i), {1'b0, tbl[i].e1});
`endif
      @(negedge clk);
      pop_cmp({1'b0, rd_data[0]});
      pop_cmp({1'b0, rd_data[1]});
    end
    next_cycle();
    idle_in();

    // Debug read of addr 9; ack exactly one cycle after acceptance.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    chk_ack("dbgrd_ack_before", 1'b0);
    next_cycle();
    dbg_req = 1'b0;
    chk_ack("dbgrd_ack", 1'b1);
    push("dbgrd_rdata", {1'b0, 32'h0000_0F0F});
    pop_cmp({1'b0, dbg_rdata});
    next_cycle();
    chk_ack("dbgrd_ack_after", 1'b0);

    // Request held through DONE is a fresh access in the following IDLE cycle.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    next_cycle();
    chk_ack("held_ack1", 1'b1);
    push("held_rdata", {1'b0, 32'hBBBB_0002});
    pop_cmp({1'b0, dbg_rdata});
    next_cycle();
    chk_ack("held_gap", 1'b0);
    next_cycle();
    chk_ack("held_ack2", 1'b1);
    dbg_req = 1'b0;
    next_cycle();

    // Debug write of 0x55 to addr 3 stalled by three cycles of core writes.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h55;
    wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 32'h0000_0A0A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_ack($sformatf("stall_ack_c%0d", c), 1'b0);
      next_cycle();
    end
    wr_en = '0;
    chk_ack("stall_ack_c3", 1'b0);
    chk_rd("stall_addr3_unwritten", 5'd3, 32'h0);
    next_cycle();
    dbg_req = 1'b0;
    chk_ack("dbgwr_ack", 1'b1);
    chk_rd("dbgwr_addr3", 5'd3, 32'h55);
    push("dbgwr_rdata_kept", {1'b0, 32'hBBBB_0002});
    pop_cmp({1'b0, dbg_rdata});
    next_cycle();
    chk_ack("dbgwr_ack_after", 1'b0);

    // Abort: request dropped while stalled, no write and no ack.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h77;
    wr_en = 2'b10; wr_addr[1] = 5'd13; wr_data[1] = 32'h1;
    next_cycle();
    dbg_req = 1'b0; wr_en = '0;
    chk_ack("abort_ack0", 1'b0);
    next_cycle();
    chk_ack("abort_ack1", 1'b0);
    next_cycle();
    chk_ack("abort_ack2", 1'b0);
    chk_rd("abort_addr12", 5'd12, 32'h0);

    // Debug write to the zero register is acknowledged but dropped.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
    next_cycle();
    dbg_req = 1'b0;
    chk_ack("zero_wr_ack", 1'b1);
    chk_rd("zero_wr_addr0", 5'd0, 32'h0);
    next_cycle();

    // Reset while in DONE drops the ack immediately and clears state.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    next_cycle();
    dbg_req = 1'b0;
    chk_ack("rstdone_ack_pre", 1'b1);
    rst = 1'b1;
    #1;
    chk_ack("rstdone_ack", 1'b0);
    push("rstdone_rdata", '0);
    pop_cmp({1'b0, dbg_rdata});
    chk_rd("rstdone_addr9", 5'd9, 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    chk_ack("rstdone_no_ack", 1'b0);

    if (sb_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
